// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH mode-selectable storage bits (D / T / JK / SR) sharing one
// clock, reset, enable and mode. SR=11 resolves to a defined value chosen by
// SR_POLICY. Each SR=11 event is also logged in sticky per-bit flags and in a
// saturating per-edge event counter.
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err_bits,
    output logic             sr_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_JK = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ill;
    logic [WIDTH-1:0] err_bits_next;
    logic [CNT_W-1:0] err_cnt_base;
    logic [CNT_W-1:0] err_cnt_next;

    // Resolution of S=R=1. Unknown policy values fall back to hold, so q
    // always stays at a known value.
    function automatic logic sr_illegal_next(input logic cur);
        case (SR_POLICY)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~cur;
            default: return cur;
        endcase
    endfunction

    // Per-bit next state for the selected mode
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_D: q_next[i] = a[i];
                MODE_T: q_next[i] = q[i] ^ a[i];
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   q_next[i] = ~q[i];
                        default: q_next[i] = q[i];
                    endcase
                end
                default: begin
                    case ({a[i], b[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   q_next[i] = sr_illegal_next(q[i]);
                        default: q_next[i] = q[i];
                    endcase
                end
            endcase
        end
    end

    // Illegal-event detection and error bookkeeping. The clear is applied
    // first, so an event on a clearing edge is still recorded.
    always_comb begin
        ill           = (en && mode == 2'b11) ? (a & b) : '0;
        err_bits_next = (clr ? '0 : err_bits) | ill;
        err_cnt_base  = clr ? '0 : err_cnt;
        err_cnt_next  = err_cnt_base;
        if ((|ill) && err_cnt_base != CNT_MAX) begin
            err_cnt_next = err_cnt_base + CNT_W'(1);
        end
    end

    // Storage bits; the whole bank holds while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    // Error state; updated every edge so that clr works while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_bits <= '0;
            err_cnt  <= '0;
        end else begin
            err_bits <= err_bits_next;
            err_cnt  <= err_cnt_next;
        end
    end

    assign qbar   = ~q;
    assign sr_err = |err_bits;

endmodule
